// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with start/stop/clear/load control and a
// multiplexed digit scanner driving a shared 7-segment decoder.
module bcd_scan_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        up,
  output logic [3:0]  bcd_out,
  output logic        en_out,
  output logic [3:0]  digit_sel,
  output logic [15:0] count,
  output logic        running,
  output logic        carry
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [15:0]   count_reg, count_next;
  logic          carry_reg, carry_next;
  logic [15:0]   inc_val, dec_val, load_clean;
  logic [4:0]    inc_c, dec_b, zero_from;
  logic          tick;

  logic [SW-1:0] scan_reg;
  logic [1:0]    idx_reg, idx_next;
  logic [3:0]    digit_sel_reg;
  logic [3:0]    bcd_reg;
  logic          en_reg;
  logic          scan_wrap;

  assign inc_c[0]     = 1'b1;
  assign dec_b[0]     = 1'b1;
  assign zero_from[4] = 1'b1;

  // Per-digit ripple carry/borrow, load sanitising and leading-zero detection.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] d;
      assign d = count_reg[gi*4 +: 4];
      assign inc_val[gi*4 +: 4] = inc_c[gi] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
      assign inc_c[gi+1]        = inc_c[gi] && (d == 4'd9);
      assign dec_val[gi*4 +: 4] = dec_b[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      assign dec_b[gi+1]        = dec_b[gi] && (d == 4'd0);
      assign load_clean[gi*4 +: 4] = (load_val[gi*4 +: 4] > 4'd9) ? 4'd0 : load_val[gi*4 +: 4];
      assign zero_from[gi] = zero_from[gi+1] && (count_next[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  assign tick = (state_reg == RUN) && (presc_reg == PW'(TICK_DIV - 1));

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    count_next = count_reg;
    carry_next = 1'b0;
    if (clear) begin
      count_next = 16'h0000;
      presc_next = '0;
    end else if (load) begin
      count_next = load_clean;
      presc_next = '0;
    end else begin
      if (tick) begin
        count_next = up ? inc_val : dec_val;
        carry_next = up ? inc_c[4] : dec_b[4];
      end
      if (stop)
        state_next = IDLE;
      else if (start)
        state_next = RUN;
      // Prescaler only advances while staying in RUN; entry and exit both zero it.
      if (state_reg == IDLE || state_next == IDLE || tick)
        presc_next = '0;
      else
        presc_next = presc_reg + PW'(1);
    end
  end

  assign scan_wrap = (scan_reg == SW'(SCAN_DIV - 1));
  assign idx_next  = scan_wrap ? idx_reg + 2'd1 : idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      count_reg     <= 16'h0000;
      carry_reg     <= 1'b0;
      scan_reg      <= '0;
      idx_reg       <= 2'd0;
      digit_sel_reg <= 4'b1110;
      bcd_reg       <= 4'd0;
      en_reg        <= 1'b1;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      count_reg <= count_next;
      carry_reg <= carry_next;
      scan_reg  <= scan_wrap ? '0 : scan_reg + SW'(1);
      idx_reg   <= idx_next;
      // Slot outputs latch the count being registered on this same edge.
      if (scan_wrap) begin
        digit_sel_reg <= ~(4'b0001 << idx_next);
        bcd_reg       <= count_next[{idx_next, 2'b00} +: 4];
        en_reg        <= !(LZ_BLANK && (idx_next != 2'd0) && zero_from[idx_next]);
      end
    end
  end

  assign count     = count_reg;
  assign carry     = carry_reg;
  assign running   = (state_reg == RUN);
  assign digit_sel = digit_sel_reg;
  assign bcd_out   = bcd_reg;
  assign en_out    = en_reg;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (TICK_DIV=4, SCAN_DIV=2, LZ_BLANK=1)
// using an expectation queue drained after each clock step.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, load, up;
  logic [15:0] load_val;
  logic [3:0]  bcd_out, digit_sel;
  logic        en_out, running, carry;
  logic [15:0] count;

  bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(2), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .up(up), .bcd_out(bcd_out),
    .en_out(en_out), .digit_sel(digit_sel), .count(count),
    .running(running), .carry(carry)
  );

  always #5 clk = ~clk;

  localparam int S_COUNT = 0, S_RUN = 1, S_CARRY = 2, S_SEL = 3, S_BCD = 4, S_EN = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [15:0] observed(int sig);
    case (sig)
      S_COUNT: return count;
      S_RUN:   return {15'd0, running};
      S_CARRY: return {15'd0, carry};
      S_SEL:   return {12'd0, digit_sel};
      S_BCD:   return {12'd0, bcd_out};
      default: return {15'd0, en_out};
    endcase
  endfunction

  task automatic expect_sig(string tag, int sig, logic [15:0] e);
    exp_t x;
    x.tag = tag; x.sig = sig; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = observed(x.sig);
      n_checks++;
      assert (obs === x.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      $display("check %s: observed %h expected %h", x.tag, obs, x.exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sel(logic [3:0] target, string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (digit_sel === target) found = 1'b1;
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("FAIL %s: observed digit_sel %b expected %b within 20 cycles", tag, digit_sel, target);
  endtask

  logic [3:0]  ds;
  logic [15:0] eb;
  int          slot;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    up = 1'b1; load_val = 16'h0000;
    step(1);
    // Reset state
    expect_sig("rst_count", S_COUNT, 16'h0000);
    expect_sig("rst_running", S_RUN, 16'd0);
    expect_sig("rst_carry", S_CARRY, 16'd0);
    expect_sig("rst_sel", S_SEL, 16'h000E);
    expect_sig("rst_bcd", S_BCD, 16'h0000);
    expect_sig("rst_en", S_EN, 16'd1);
    step(1);
    check_all();
    rst = 1'b0;

    // Start pulse, count up from zero
    start = 1'b1; up = 1'b1;
    expect_sig("start_running", S_RUN, 16'd1);
    expect_sig("start_count", S_COUNT, 16'h0000);
    step(1); check_all();
    start = 1'b0;
    expect_sig("pre_tick1", S_COUNT, 16'h0000);
    step(3); check_all();
    expect_sig("tick1", S_COUNT, 16'h0001);
    expect_sig("tick1_carry", S_CARRY, 16'd0);
    step(1); check_all();
    expect_sig("tick2", S_COUNT, 16'h0002);
    step(4); check_all();

    // Up wrap 9999 -> 0000
    stop = 1'b1;
    expect_sig("stop_running", S_RUN, 16'd0);
    step(1); check_all();
    stop = 1'b0; load = 1'b1; load_val = 16'h9998;
    expect_sig("load_9998", S_COUNT, 16'h9998);
    step(1); check_all();
    load = 1'b0; start = 1'b1;
    step(1); start = 1'b0;
    step(3);
    expect_sig("up_9999", S_COUNT, 16'h9999);
    expect_sig("up_9999_carry", S_CARRY, 16'd0);
    step(1); check_all();
    step(3);
    expect_sig("up_wrap", S_COUNT, 16'h0000);
    expect_sig("up_wrap_carry", S_CARRY, 16'd1);
    step(1); check_all();
    expect_sig("up_carry_drop", S_CARRY, 16'd0);
    step(1); check_all();

    // Down wrap 0000 -> 9999
    stop = 1'b1; step(1); stop = 1'b0;
    load = 1'b1; load_val = 16'h0000; step(1); load = 1'b0;
    up = 1'b0; start = 1'b1; step(1); start = 1'b0;
    step(3);
    expect_sig("dn_wrap", S_COUNT, 16'h9999);
    expect_sig("dn_wrap_carry", S_CARRY, 16'd1);
    step(1); check_all();
    expect_sig("dn_carry_drop", S_CARRY, 16'd0);
    step(1); check_all();
    stop = 1'b1; step(1); stop = 1'b0;

    // Load sanitising of non-BCD digits
    load = 1'b1; load_val = 16'h00A5;
    expect_sig("load_00A5", S_COUNT, 16'h0005);
    step(1); check_all();
    load_val = 16'hFA5B;
    expect_sig("load_FA5B", S_COUNT, 16'h0050);
    step(1); check_all();

    // Scan sequence with leading-zero blanking on 0042
    load_val = 16'h0042;
    step(1); load = 1'b0;
    wait_sel(4'b0111, "scan_sync3");
    wait_sel(4'b1110, "scan_sync0");
    for (int k = 0; k < 8; k++) begin
      slot = k / 2;
      ds = ~(4'b0001 << slot);
      eb = (slot == 0) ? 16'd2 : (slot == 1) ? 16'd4 : 16'd0;
      expect_sig($sformatf("scan_sel%0d", k), S_SEL, {12'd0, ds});
      expect_sig($sformatf("scan_bcd%0d", k), S_BCD, eb);
      expect_sig($sformatf("scan_en%0d", k), S_EN, (slot < 2) ? 16'd1 : 16'd0);
      check_all();
      step(1);
    end

    // start and stop together keep IDLE
    start = 1'b1; stop = 1'b1;
    expect_sig("start_stop_idle", S_RUN, 16'd0);
    step(1); check_all();
    stop = 1'b0; up = 1'b1;
    step(1); start = 1'b0;
    step(3);
    // Clear on the tick cycle discards the step
    clear = 1'b1;
    expect_sig("clear_tick_count", S_COUNT, 16'h0000);
    expect_sig("clear_tick_running", S_RUN, 16'd1);
    expect_sig("clear_tick_carry", S_CARRY, 16'd0);
    step(1); check_all();
    clear = 1'b0;
    expect_sig("post_clear_hold", S_COUNT, 16'h0000);
    step(3); check_all();
    expect_sig("post_clear_tick", S_COUNT, 16'h0001);
    step(1); check_all();

    // Reset during RUN
    stop = 1'b1; step(1); stop = 1'b0;
    load = 1'b1; load_val = 16'h0137; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    rst = 1'b1;
    expect_sig("runrst_count", S_COUNT, 16'h0000);
    expect_sig("runrst_running", S_RUN, 16'd0);
    expect_sig("runrst_sel", S_SEL, 16'h000E);
    step(1); check_all();
    rst = 1'b0;
    expect_sig("after_rst_count", S_COUNT, 16'h0000);
    expect_sig("after_rst_running", S_RUN, 16'd0);
    step(6); check_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per count step; SHALL be >= 2.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per display digit slot; SHALL be >= 2.
REQ-003 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 start  in  1  level, sampled each cycle; requests counting.
REQ-007 stop  in  1  level; requests halt.
REQ-008 clear  in  1  level; forces count to 0000.
REQ-009 load  in  1  level; loads load_val.
REQ-010 load_val  in  16  four BCD digits; [3:0] is digit 0 (least significant).
REQ-011 up  in  1  direction: 1 increments, 0 decrements.
REQ-012 bcd_out  out  4  BCD digit currently scanned; feeds the 7-segment decoder input.
REQ-013 en_out  out  1  decoder enable; 0 blanks the current digit.
REQ-014 digit_sel  out  4  active-low digit strobe, exactly one bit low.
REQ-015 count  out  16  current four-digit BCD value.
REQ-016 running  out  1  high in RUN.
REQ-017 carry  out  1  one-cycle pulse on wrap.

Function
REQ-018 Two-state FSM: IDLE, RUN. Start-up and reset state is IDLE.
REQ-019 Command priority per cycle: clear > load > stop > start.
REQ-020 IDLE->RUN when start=1 and stop=0; RUN->IDLE when stop=1; start and stop together leave or put the FSM in IDLE.
REQ-021 clear: count <= 0000, prescaler <= 0, FSM state unchanged.
REQ-022 load: count <= load_val, with any digit > 9 replaced by 0; prescaler <= 0; FSM state unchanged.
REQ-023 Prescaler counts 0..TICK_DIV-1 only in RUN; it is held at 0 in IDLE and zeroed on the IDLE->RUN transition.
REQ-024 Tick fires on the cycle the prescaler equals TICK_DIV-1; the count changes on the following edge.
REQ-025 First tick after entering RUN occurs exactly TICK_DIV cycles after the start cycle.
REQ-026 Increment is decimal, with ripple carry per digit (digit 9 -> 0, carry into the next digit).
REQ-027 Decrement is decimal, with borrow per digit (digit 0 -> 9, borrow from the next digit).
REQ-028 9999 up-tick -> 0000 with carry=1 for one cycle; 0000 down-tick -> 9999 with carry=1 for one cycle; carry=0 otherwise.
REQ-029 A tick coinciding with clear or load is discarded: no step, no carry.
REQ-030 up is sampled on the tick cycle; a direction change affects the next step only.
REQ-031 Scan counter runs free regardless of FSM state, counting 0..SCAN_DIV-1.
REQ-032 At SCAN_DIV-1 the digit index advances 0->1->2->3->0.
REQ-033 Registered outputs: digit_sel = ~(1<<idx), bcd_out = digit[idx], en_out; all three update on the same edge.
REQ-034 With LZ_BLANK=1, en_out=0 when idx>0 and digit[idx] through digit[3] are all zero; digit 0 is never blanked.
REQ-035 With LZ_BLANK=0, en_out=1 always.
REQ-036 bcd_out/en_out reflect the count value registered on the edge the slot begins.

Reset
REQ-037 On rst=1 at a clock edge: FSM=IDLE, count=0000, prescaler=0, scan counter=0, idx=0.
REQ-038 On rst=1 at a clock edge: digit_sel=4'b1110, bcd_out=0000, en_out=1, running=0, carry=0.
REQ-039 rst overrides all inputs; reset during RUN discards any pending tick.
REQ-040 Operation resumes only on a later start.

Verification (TICK_DIV=4, SCAN_DIV=2, LZ_BLANK=1)
REQ-041 Reset then start pulse, up=1 -> running=1 next cycle; count 0001 four cycles after start, 0002 after eight.
REQ-042 load 9998, up=1, start -> count 9999 then 0000; carry=1 exactly one cycle at the wrap.
REQ-043 load 0000, up=0, start -> count 9999, carry pulse; load_val 16'h00A5 -> count 0005.
REQ-044 count=0042 in IDLE -> scan sequence digit_sel 1110/1101/1011/0111 with bcd_out 2/4/0/0, en_out 1/1/0/0, each slot 2 cycles.
REQ-045 start and stop both high -> stays IDLE; clear on the tick cycle in RUN -> count 0000, no step, running stays 1.
REQ-046 rst during RUN with count 0137 -> next cycle count 0000, running=0, digit_sel 1110.
